// File: rtl/me_pkg.sv
// me_pkg: shared constants and types for the motion-estimation search controller.
//   N_PART        number of partition SADs returned by the 16x16 adder tree
//   P*_BASE       index of the first partition of each shape within a result vector
//   me_state_t    controller FSM states
package me_pkg;

    localparam int unsigned N_PART = 41;

    // Partition layout inside the flat SAD vector (4x4 entries are row-major [i][j]).
    localparam int unsigned P4X4_BASE   = 0;
    localparam int unsigned P4X8_BASE   = 16;
    localparam int unsigned P8X4_BASE   = 24;
    localparam int unsigned P8X8_BASE   = 32;
    localparam int unsigned P16X8_BASE  = 36;
    localparam int unsigned P8X16_BASE  = 38;
    localparam int unsigned P16X16      = 40;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } me_state_t;

endpackage

// File: rtl/me_part_min.sv
// me_part_min: running minimum SAD and its motion vector for one partition.
//   clk, rst       clock and synchronous active-low reset
//   clear          restart the search: best_sad to all-ones, best MV to zero
//   upd            a result is presented on sad/mvx/mvy this cycle
//   sad, mvx, mvy  candidate SAD and the MV it belongs to
//   best_*         current minimum and its MV
module me_part_min
    import me_pkg::*;
#(
    parameter int unsigned SAD_W = 16,
    parameter int unsigned MV_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             upd,
    input  logic [SAD_W-1:0] sad,
    input  logic [MV_W-1:0]  mvx,
    input  logic [MV_W-1:0]  mvy,
    output logic [SAD_W-1:0] best_sad,
    output logic [MV_W-1:0]  best_mvx,
    output logic [MV_W-1:0]  best_mvy
);

    logic [SAD_W-1:0] sad_q;
    logic [MV_W-1:0]  mvx_q;
    logic [MV_W-1:0]  mvy_q;

    // Strict compare: on a tie the earlier raster candidate is kept.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            sad_q <= '1;
            mvx_q <= '0;
            mvy_q <= '0;
        end else if (upd && (sad < sad_q)) begin
            sad_q <= sad;
            mvx_q <= mvx;
            mvy_q <= mvy;
        end
    end

    assign best_sad = sad_q;
    assign best_mvx = mvx_q;
    assign best_mvy = mvy_q;

endmodule

// File: rtl/me_search_ctrl.sv
// me_search_ctrl: full-search motion-estimation controller.
// Issues candidate MVs over [-SR,+SR]^2 in raster order (x fastest) and folds the
// returned partition SAD vectors into per-partition minima.
//   clk, rst             clock, synchronous active-low reset
//   start                begin a search (only honoured in IDLE)
//   busy, done           search in progress / one-cycle completion pulse
//   cand_valid/ready     candidate handshake; cand_mvx/cand_mvy signed MV
//   sad_valid, sad_in    returned SAD vector, in issue order, any latency
//   best_sad/mvx/mvy     per-partition minimum SAD and MV, flat packed
module me_search_ctrl
    import me_pkg::*;
#(
    parameter int unsigned SAD_W = 16,
    parameter int unsigned SR    = 8,
    parameter int unsigned MV_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    cand_valid,
    input  logic                    cand_ready,
    output logic [MV_W-1:0]         cand_mvx,
    output logic [MV_W-1:0]         cand_mvy,
    input  logic                    sad_valid,
    input  logic [N_PART*SAD_W-1:0] sad_in,
    output logic [N_PART*SAD_W-1:0] best_sad,
    output logic [N_PART*MV_W-1:0]  best_mvx,
    output logic [N_PART*MV_W-1:0]  best_mvy
);

    localparam int unsigned TOTAL = (2 * SR + 1) ** 2;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam logic [MV_W-1:0] MV_MAX = MV_W'(SR);
    localparam logic [MV_W-1:0] MV_MIN = MV_W'(0) - MV_MAX;
    localparam logic [CNT_W-1:0] CNT_TOTAL = CNT_W'(TOTAL);

    me_state_t state_q, state_d;
    logic             valid_q, valid_d;
    logic [MV_W-1:0]  ix_q, ix_d, iy_q, iy_d;   // issue position
    logic [MV_W-1:0]  rx_q, rx_d, ry_q, ry_d;   // MV of the next returned result
    logic [CNT_W-1:0] rcnt_q, rcnt_d;

    logic hs;
    logic last_issue;
    logic start_acc;
    logic upd;

    assign hs         = valid_q && cand_ready;
    assign last_issue = hs && (ix_q == MV_MAX) && (iy_q == MV_MAX);
    assign start_acc  = (state_q == IDLE) && start;
    assign upd        = sad_valid && ((state_q == ISSUE) || (state_q == DRAIN)) &&
                        (rcnt_q < CNT_TOTAL);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ix_q    <= '0;
            iy_q    <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ix_q    <= ix_d;
            iy_q    <= iy_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            rcnt_q  <= rcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        ix_d    = ix_q;
        iy_d    = iy_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        rcnt_d  = rcnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    valid_d = 1'b1;
                    ix_d    = MV_MIN;
                    iy_d    = MV_MIN;
                    rx_d    = MV_MIN;
                    ry_d    = MV_MIN;
                    rcnt_d  = '0;
                end
            end
            ISSUE: begin
                if (hs) begin
                    // The final MV is held after the last handshake; valid drops instead.
                    if (last_issue) begin
                        valid_d = 1'b0;
                        state_d = DRAIN;
                    end else if (ix_q == MV_MAX) begin
                        ix_d = MV_MIN;
                        iy_d = iy_q + 1'b1;
                    end else begin
                        ix_d = ix_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (rcnt_q == CNT_TOTAL) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Result tracking runs alongside issue; upd is never true in IDLE.
        if (upd) begin
            rcnt_d = rcnt_q + 1'b1;
            if (rx_q == MV_MAX) begin
                rx_d = MV_MIN;
                ry_d = ry_q + 1'b1;
            end else begin
                rx_d = rx_q + 1'b1;
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign cand_valid = valid_q;
    assign cand_mvx   = ix_q;
    assign cand_mvy   = iy_q;

    for (genvar p = 0; p < N_PART; p++) begin : g_part
        me_part_min #(
            .SAD_W (SAD_W),
            .MV_W  (MV_W)
        ) u_part (
            .clk      (clk),
            .rst      (rst),
            .clear    (start_acc),
            .upd      (upd),
            .sad      (sad_in[p*SAD_W +: SAD_W]),
            .mvx      (rx_q),
            .mvy      (ry_q),
            .best_sad (best_sad[p*SAD_W +: SAD_W]),
            .best_mvx (best_mvx[p*MV_W +: MV_W]),
            .best_mvy (best_mvy[p*MV_W +: MV_W])
        );
    end

endmodule
